// File: rtl/sad_block_loader_if.sv
// Pixel-pair stream into the SAD block loader and the 4x8 block bus it drives toward the SAD.

interface sad_block_loader_if #(
  parameter int unsigned WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sof;
  logic [WIDTH-1:0]      in_ori;
  logic [WIDTH-1:0]      in_can;
  logic                  hold;
  logic [32*WIDTH-1:0]   out_ori;
  logic [32*WIDTH-1:0]   out_can;
  logic                  out_en;
  logic [15:0]           blk_cnt;
  logic                  sof_err;

  modport master (
    output in_valid, in_sof, in_ori, in_can, hold,
    input  in_ready, out_ori, out_can, out_en, blk_cnt, sof_err
  );

  modport slave (
    input  in_valid, in_sof, in_ori, in_can, hold,
    output in_ready, out_ori, out_can, out_en, blk_cnt, sof_err
  );
endinterface

// File: rtl/sad_block_loader.sv
// Collects 32 raster-ordered pixel pairs into a 4x8 block and issues it to the SAD when
// downstream is not holding; in_sof realigns framing and flags broken blocks.

module sad_block_loader #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  sad_block_loader_if.slave bus
);

  localparam int unsigned NumPix = 32;

  logic [WIDTH-1:0]        coll_ori_q [NumPix];
  logic [WIDTH-1:0]        coll_can_q [NumPix];
  logic [NumPix*WIDTH-1:0] coll_ori_flat, coll_can_flat;
  logic [NumPix*WIDTH-1:0] out_ori_q, out_can_q;
  logic [4:0]              wr_idx_q, wr_idx_d, wr_slot;
  logic                    full_q, full_d;
  logic                    out_en_q;
  logic                    sof_err_q, sof_err_d;
  logic [15:0]             blk_cnt_q, blk_cnt_d;
  logic                    accept, issue, wr_en;

  assign bus.in_ready = ~full_q | ~bus.hold;
  assign accept       = bus.in_valid & bus.in_ready;
  assign issue        = full_q & ~bus.hold;

  always_comb begin
    wr_idx_d  = wr_idx_q;
    full_d    = full_q & ~issue;
    sof_err_d = 1'b0;
    wr_en     = 1'b0;
    wr_slot   = wr_idx_q;
    blk_cnt_d = issue ? blk_cnt_q + 16'd1 : blk_cnt_q;
    if (accept) begin
      if (bus.in_sof) begin
        // A new start-of-frame always wins; any partial block is abandoned.
        wr_en     = 1'b1;
        wr_slot   = 5'd0;
        wr_idx_d  = 5'd1;
        sof_err_d = (wr_idx_q != 5'd0);
      end else if (wr_idx_q == 5'd0) begin
        sof_err_d = 1'b1;
      end else begin
        wr_en    = 1'b1;
        wr_idx_d = wr_idx_q + 5'd1;
        if (wr_idx_q == 5'd31) begin
          full_d = 1'b1;
        end
      end
    end
  end

  // Collect bank needs no reset: every slot is rewritten before a block can complete.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      coll_ori_q[wr_slot] <= bus.in_ori;
      coll_can_q[wr_slot] <= bus.in_can;
    end
  end

  always_comb begin
    coll_ori_flat = '0;
    coll_can_flat = '0;
    for (int k = 0; k < NumPix; k++) begin
      coll_ori_flat[k*WIDTH +: WIDTH] = coll_ori_q[k];
      coll_can_flat[k*WIDTH +: WIDTH] = coll_can_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q  <= 5'd0;
      full_q    <= 1'b0;
      out_en_q  <= 1'b0;
      sof_err_q <= 1'b0;
      blk_cnt_q <= 16'd0;
      out_ori_q <= '0;
      out_can_q <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      full_q    <= full_d;
      out_en_q  <= issue;
      sof_err_q <= sof_err_d;
      blk_cnt_q <= blk_cnt_d;
      if (issue) begin
        out_ori_q <= coll_ori_flat;
        out_can_q <= coll_can_flat;
      end
    end
  end

  assign bus.out_ori = out_ori_q;
  assign bus.out_can = out_can_q;
  assign bus.out_en  = out_en_q;
  assign bus.blk_cnt = blk_cnt_q;
  assign bus.sof_err = sof_err_q;

endmodule

// File: tb/tb_sad_block_loader.sv
// Directed and random stimulus for sad_block_loader, checked cycle by cycle against a
// block-level model (pixel count, queue of completed blocks).

module tb_sad_block_loader;

  localparam int unsigned Width = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sad_block_loader_if #(.WIDTH(Width)) bus ();

  sad_block_loader #(.WIDTH(Width)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_cnt;
  logic [7:0]   m_ori [32];
  logic [7:0]   m_can [32];
  logic [255:0] q_ori [$];
  logic [255:0] q_can [$];
  logic [255:0] e_out_ori, e_out_can;
  logic         e_out_en, e_sof_err;
  int           e_blk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    q_ori.delete();
    q_can.delete();
    e_out_ori = '0;
    e_out_can = '0;
    e_out_en  = 1'b0;
    e_sof_err = 1'b0;
    e_blk     = 0;
  endtask

  task automatic check_outputs();
    check("out_en", bus.out_en, e_out_en);
    check("sof_err", bus.sof_err, e_sof_err);
    check("blk_cnt", bus.blk_cnt, 16'(e_blk));
    check("out_ori", bus.out_ori, e_out_ori);
    check("out_can", bus.out_can, e_out_can);
  endtask

  // One clock cycle: drive inputs, predict, advance, compare.
  task automatic cycle(input logic v, input logic s, input logic [7:0] o, input logic [7:0] c,
                       input logic h);
    logic rdy;
    logic [255:0] po, pc;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_ori   = o;
    bus.in_can   = c;
    bus.hold     = h;
    #1;
    rdy = !(q_ori.size() > 0 && h);
    check("in_ready", bus.in_ready, rdy);
    e_out_en  = 1'b0;
    e_sof_err = 1'b0;
    if (q_ori.size() > 0 && !h) begin
      e_out_ori = q_ori.pop_front();
      e_out_can = q_can.pop_front();
      e_out_en  = 1'b1;
      e_blk     = (e_blk + 1) % 65536;
    end
    if (v && rdy) begin
      if (s) begin
        e_sof_err = (m_cnt != 0);
        m_cnt = 0;
      end
      if (m_cnt == 0 && !s) begin
        e_sof_err = 1'b1;
      end else begin
        m_ori[m_cnt] = o;
        m_can[m_cnt] = c;
        m_cnt++;
        if (m_cnt == 32) begin
          for (int k = 0; k < 32; k++) begin
            po[k*8 +: 8] = m_ori[k];
            pc[k*8 +: 8] = m_can[k];
          end
          q_ori.push_back(po);
          q_can.push_back(pc);
          m_cnt = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b1;
    bus.in_ori   = 8'hA5;
    bus.in_can   = 8'h5A;
    bus.hold     = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs();
  endtask

  initial begin
    logic v, s, h;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_ori   = '0;
    bus.in_can   = '0;
    bus.hold     = 1'b0;
    model_reset();

    // Reset state
    do_reset();

    // Basic block: ori=k, can=255-k
    for (int k = 0; k < 32; k++) cycle(1'b1, k == 0, 8'(k), 8'(255 - k), 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("blk_cnt_after_first", bus.blk_cnt, 16'd1);

    // Hold while full: source stalled, next block's first pair taken on the issue edge
    do_reset();
    for (int k = 0; k < 32; k++) cycle(1'b1, k == 0, 8'(3 * k), 8'(k + 100), k == 31);
    repeat (10) cycle(1'b1, 1'b1, 8'hEE, 8'h11, 1'b1);
    cycle(1'b1, 1'b1, 8'hEE, 8'h11, 1'b0);
    for (int k = 1; k < 32; k++) cycle(1'b1, 1'b0, 8'(k), 8'(k ^ 8'h3C), 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Re-sof after 20 pairs
    for (int k = 0; k < 20; k++) cycle(1'b1, k == 0, 8'(k + 7), 8'(k), 1'b0);
    cycle(1'b1, 1'b1, 8'hC3, 8'h3C, 1'b0);
    for (int k = 1; k < 32; k++) cycle(1'b1, 1'b0, 8'(k * 5), 8'(k * 9), 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Pairs without sof at slot 0 are dropped
    do_reset();
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 8'(k), 8'(k), 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset mid-block, then a fresh block
    for (int k = 0; k < 16; k++) cycle(1'b1, k == 0, 8'hF0, 8'h0F, 1'b0);
    do_reset();
    for (int k = 0; k < 32; k++) cycle(1'b1, k == 0, 8'(k + 1), 8'(k + 2), 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Back-to-back blocks at full rate
    for (int i = 0; i < 3 * 32 + 2; i++) begin
      cycle(1'b1, m_cnt == 0, 8'($urandom), 8'($urandom), 1'b0);
    end

    // Random traffic with backpressure and stray sof
    for (int i = 0; i < 800; i++) begin
      v = ($urandom_range(0, 3) != 0);
      h = ($urandom_range(0, 3) == 0);
      s = (m_cnt == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 40) == 0);
      cycle(v, s, 8'($urandom), 8'($urandom), h);
    end
    repeat (3) cycle(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
